// File: rtl/sram_video_port.sv
// Frame-buffer SRAM port: scrolled address generation and a 2-cycle read/unpack pipeline.
// Defining SRAM_VIDEO_PORT_WRITE_EN adds the blanking-time write channel and its FSM.
module sram_video_port #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 16,
   parameter int PIX_W      = 8,
   parameter int ROW_STRIDE = 4114,
   parameter int FPTR_W     = 13
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              VidActive,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [FPTR_W-1:0] FramePtr,
   input  logic              WrReq,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [DATA_W-1:0] WrData,
   output logic              WrAck,
   output logic [ADDR_W-1:0] SRAM_Addr,
   input  logic [DATA_W-1:0] SRAM_DQ_In,
   output logic [DATA_W-1:0] SRAM_DQ_Out,
   output logic              SRAM_DQ_OE,
   output logic              CE,
   output logic              UB,
   output logic              LB,
   output logic              OE,
   output logic              WE,
   output logic [PIX_W-1:0]  Pixel,
   output logic              PixelValid
);
   localparam int PPW   = DATA_W / PIX_W;
   localparam int SHIFT = $clog2(PPW);
   localparam int LIN_W = ADDR_W + SHIFT;
   localparam int K_W   = (SHIFT > 0) ? SHIFT : 1;

   // Stage A holds the linear pixel index, stage B the SRAM address cycle, stage C the pixel.
   logic [LIN_W-1:0]  lin_d, lin_q;
   logic              vid_a_d, vid_a_q;
   logic [ADDR_W-1:0] sram_addr_d, sram_addr_q;
   logic [K_W-1:0]    k_d, k_q;
   logic              vid_b_d, vid_b_q;
   logic              slot_d, slot_q;
   logic [PIX_W-1:0]  pixel_d, pixel_q;
   logic              pixel_valid_d, pixel_valid_q;
   logic              oe_d, oe_q;
   logic [ADDR_W-1:0] rd_addr;

`ifdef SRAM_VIDEO_PORT_WRITE_EN
   typedef enum logic [1:0] {IDLE, W_SETUP, W_PULSE, W_HOLD} state_t;
   state_t            state_d, state_q;
   logic [DATA_W-1:0] dq_out_d, dq_out_q;
   logic              we_d, we_q;
   logic              dq_oe_d, dq_oe_q;
   logic              wr_ack_d, wr_ack_q;
`endif

   always_comb begin
      lin_d         = LIN_W'(32'(FramePtr) + 32'(DrawX) + 32'(DrawY) * 32'(ROW_STRIDE));
      vid_a_d       = VidActive;
      rd_addr       = ADDR_W'(lin_q >> SHIFT);
      k_d           = K_W'(lin_q & LIN_W'(PPW - 1));
      vid_b_d       = vid_a_q;
      pixel_d       = slot_q ? PIX_W'(SRAM_DQ_In >> (32'(k_q) * 32'(PIX_W))) : '0;
      pixel_valid_d = slot_q & vid_b_q;
`ifdef SRAM_VIDEO_PORT_WRITE_EN
      state_d = state_q;
      case (state_q)
         IDLE:    if (WrReq && !VidActive) state_d = W_SETUP;
         W_SETUP: state_d = W_PULSE;
         W_PULSE: state_d = W_HOLD;
         default: state_d = IDLE;
      endcase
      dq_out_d    = dq_out_q;
      sram_addr_d = rd_addr;
      // Address and data are latched on entry and held across the whole write.
      if (state_q == IDLE && state_d == W_SETUP) begin
         sram_addr_d = WrAddr;
         dq_out_d    = WrData;
      end else if (state_d != IDLE) begin
         sram_addr_d = sram_addr_q;
      end
      slot_d   = (state_d == IDLE);
      oe_d     = !slot_d;
      we_d     = (state_d != W_PULSE);
      dq_oe_d  = !slot_d;
      wr_ack_d = (state_d == W_HOLD);
`else
      sram_addr_d = rd_addr;
      slot_d      = 1'b1;
      oe_d        = 1'b0;
`endif
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lin_q         <= '0;
         vid_a_q       <= 1'b0;
         sram_addr_q   <= '0;
         k_q           <= '0;
         vid_b_q       <= 1'b0;
         slot_q        <= 1'b0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         oe_q          <= 1'b1;
`ifdef SRAM_VIDEO_PORT_WRITE_EN
         state_q       <= IDLE;
         dq_out_q      <= '0;
         we_q          <= 1'b1;
         dq_oe_q       <= 1'b0;
         wr_ack_q      <= 1'b0;
`endif
      end else begin
         lin_q         <= lin_d;
         vid_a_q       <= vid_a_d;
         sram_addr_q   <= sram_addr_d;
         k_q           <= k_d;
         vid_b_q       <= vid_b_d;
         slot_q        <= slot_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         oe_q          <= oe_d;
`ifdef SRAM_VIDEO_PORT_WRITE_EN
         state_q       <= state_d;
         dq_out_q      <= dq_out_d;
         we_q          <= we_d;
         dq_oe_q       <= dq_oe_d;
         wr_ack_q      <= wr_ack_d;
`endif
      end
   end

`ifdef SRAM_VIDEO_PORT_WRITE_EN
   assign WE          = we_q;
   assign SRAM_DQ_OE  = dq_oe_q;
   assign SRAM_DQ_Out = dq_out_q;
   assign WrAck       = wr_ack_q;
`else
   logic unused_wr;
   assign unused_wr   = ^{WrReq, WrAddr, WrData};
   assign WE          = 1'b1;
   assign SRAM_DQ_OE  = 1'b0;
   assign SRAM_DQ_Out = '0;
   assign WrAck       = 1'b0;
`endif

   assign SRAM_Addr  = sram_addr_q;
   assign OE         = oe_q;
   assign CE         = 1'b0;
   assign UB         = 1'b0;
   assign LB         = 1'b0;
   assign Pixel      = pixel_q;
   assign PixelValid = pixel_valid_q;
endmodule

// File: tb/tb_sram_video_port.sv
// Bench for sram_video_port: default-width instance plus a 10-bit-address instance for
// wrap-around, both checked every cycle against a behavioural slot/burst model.
`timescale 1ns/1ps
module tb_sram_video_port;
   localparam int MAXC   = 2048;
   localparam int STRIDE = 4114;
`ifdef SRAM_VIDEO_PORT_WRITE_EN
   localparam bit WR_EN = 1'b1;
`else
   localparam bit WR_EN = 1'b0;
`endif

   // clock / reset and stimulus
   logic        clk = 1'b0;
   logic        reset;
   logic        vid_active;
   logic [9:0]  draw_x, draw_y;
   logic [12:0] frame_ptr;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic [15:0] sram_dq_in;

   logic        wr_ack, dq_oe, ce, ub, lb, oe, we, pixel_valid;
   logic [19:0] sram_addr;
   logic [15:0] dq_out;
   logic [7:0]  pixel;

   logic        s_wr_req  = 1'b0;
   logic [9:0]  s_wr_addr = '0;
   logic [15:0] s_wr_data = '0;
   logic        s_wr_ack, s_dq_oe, s_ce, s_ub, s_lb, s_oe, s_we, s_pixel_valid;
   logic [9:0]  s_sram_addr;
   logic [15:0] s_dq_out;
   logic [7:0]  s_pixel;

   always #5 clk = ~clk;

   sram_video_port dut (
      .Clk(clk), .Reset(reset), .VidActive(vid_active), .DrawX(draw_x), .DrawY(draw_y),
      .FramePtr(frame_ptr), .WrReq(wr_req), .WrAddr(wr_addr), .WrData(wr_data),
      .WrAck(wr_ack), .SRAM_Addr(sram_addr), .SRAM_DQ_In(sram_dq_in), .SRAM_DQ_Out(dq_out),
      .SRAM_DQ_OE(dq_oe), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we),
      .Pixel(pixel), .PixelValid(pixel_valid)
   );

   sram_video_port #(.ADDR_W(10)) dut_narrow (
      .Clk(clk), .Reset(reset), .VidActive(vid_active), .DrawX(draw_x), .DrawY(draw_y),
      .FramePtr(frame_ptr), .WrReq(s_wr_req), .WrAddr(s_wr_addr), .WrData(s_wr_data),
      .WrAck(s_wr_ack), .SRAM_Addr(s_sram_addr), .SRAM_DQ_In(sram_dq_in), .SRAM_DQ_Out(s_dq_out),
      .SRAM_DQ_OE(s_dq_oe), .CE(s_ce), .UB(s_ub), .LB(s_lb), .OE(s_oe), .WE(s_we),
      .Pixel(s_pixel), .PixelValid(s_pixel_valid)
   );

   // scoreboard: per-edge history plus queue of read-slot tags {is_read, vid, k}
   int         h_lin [MAXC];
   int         h_slin[MAXC];
   int         h_dq  [MAXC];
   bit         h_vid [MAXC];
   bit         h_rst [MAXC];
   bit         h_occ [MAXC];
   logic [2:0] exp_q[$];
   int         last_start = -100;
   int         st_addr = 0;
   int         exp_dq_out = 0;
   int         cyc = 0;
   int         n_vec = 0;
   int         n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int lin_of(input int lw);
      return (int'(frame_ptr) + int'(draw_x) + int'(draw_y) * STRIDE) % (1 << lw);
   endfunction

   function automatic int pix_of(input int word, input int k);
      return (word >> (8 * k)) & 255;
   endfunction

   // A write accepted at edge s owns edges s..s+2; the next may start at s+4 at the earliest.
   task automatic record(input int c);
      h_rst[c] = reset;
      h_dq[c]  = int'(sram_dq_in);
      if (reset) begin
         h_lin[c] = 0; h_slin[c] = 0; h_vid[c] = 1'b0; h_occ[c] = 1'b0;
         last_start = -100;
         exp_dq_out = 0;
         exp_q.push_back(3'b000);
      end else begin
         h_lin[c]  = lin_of(21);
         h_slin[c] = lin_of(11);
         h_vid[c]  = vid_active;
         if (WR_EN && wr_req && !vid_active && (c - last_start) >= 4) begin
            last_start = c;
            st_addr    = int'(wr_addr);
            exp_dq_out = int'(wr_data);
         end
         h_occ[c] = ((c - last_start) <= 2);
         exp_q.push_back({!h_occ[c], h_vid[c-1], (h_lin[c-1] % 2) == 1});
      end
   endtask

   task automatic check_cycle(input int c);
      logic [2:0] ent;
      int         ph;
      bit         rd_prev;
      ent = 3'b000;
      if (exp_q.size() > 1) ent = exp_q.pop_front();
      if (h_rst[c]) begin
         check_eq("rst_addr", sram_addr, 0);
         check_eq("rst_oe", oe, 1);
         check_eq("rst_we", we, 1);
         check_eq("rst_dq_oe", dq_oe, 0);
         check_eq("rst_ack", wr_ack, 0);
         check_eq("rst_dq_out", dq_out, 0);
         check_eq("rst_pixel", pixel, 0);
         check_eq("rst_valid", pixel_valid, 0);
         check_eq("rst_n_addr", s_sram_addr, 0);
      end else begin
         ph = c - last_start;
         if (h_occ[c]) begin
            check_eq("wr_addr", sram_addr, st_addr);
            check_eq("wr_oe", oe, 1);
            check_eq("wr_we", we, ph != 1);
            check_eq("wr_dq_oe", dq_oe, 1);
            check_eq("wr_ack", wr_ack, ph == 2);
         end else begin
            check_eq("rd_addr", sram_addr, h_lin[c-1] >> 1);
            check_eq("rd_oe", oe, 0);
            check_eq("rd_we", we, 1);
            check_eq("rd_dq_oe", dq_oe, 0);
            check_eq("rd_ack", wr_ack, 0);
         end
         check_eq("dq_out", dq_out, exp_dq_out);
         check_eq("pixel", pixel, ent[2] ? pix_of(h_dq[c], int'(ent[0])) : 0);
         check_eq("pixel_valid", pixel_valid, ent[2] & ent[1]);
         rd_prev = !h_rst[c-1];
         check_eq("n_addr", s_sram_addr, h_slin[c-1] >> 1);
         check_eq("n_pixel", s_pixel, rd_prev ? pix_of(h_dq[c], h_slin[c-2] % 2) : 0);
         check_eq("n_valid", s_pixel_valid, rd_prev && h_vid[c-2]);
      end
      check_eq("ce_ub_lb", {ce, ub, lb}, 0);
   endtask

   task automatic step();
      @(posedge clk);
      record(cyc);
      @(negedge clk);
      check_cycle(cyc);
      cyc++;
   endtask

   function automatic bit model_ack();
      return !h_rst[cyc-1] && h_occ[cyc-1] && ((cyc - 1 - last_start) == 2);
   endfunction

   task automatic rand_coords();
      draw_x     = 10'($urandom_range(0, 799));
      draw_y     = 10'($urandom_range(0, 524));
      frame_ptr  = 13'($urandom);
      sram_dq_in = 16'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; vid_active = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      draw_x = '0; draw_y = '0; frame_ptr = '0; sram_dq_in = '0;
      @(negedge clk);
      repeat (3) step();
      reset = 1'b0;

      // unpack: lin = 3 + 4114 = 4117 -> word 2058, k = 1 -> upper byte
      frame_ptr = '0; draw_x = 10'd3; draw_y = 10'd1; vid_active = 1'b1; sram_dq_in = 16'h1111;
      step();
      draw_x = 10'd100; draw_y = 10'd7; sram_dq_in = 16'h2222;
      step();
      check_eq("unpack_addr", sram_addr, 2058);
      sram_dq_in = 16'hABCD;
      step();
      check_eq("unpack_pixel", pixel, 8'hAB);
      check_eq("unpack_valid", pixel_valid, 1);

      // wrap on the 10-bit instance: 4114 mod 2048 = 18 -> word 9, k = 0
      draw_x = 10'd0; draw_y = 10'd1; frame_ptr = '0;
      step();
      draw_x = 10'd5; sram_dq_in = 16'h0101;
      step();
      check_eq("wrap_addr", s_sram_addr, 9);
      sram_dq_in = 16'h5A3C;
      step();
      check_eq("wrap_pixel", s_pixel, 8'h3C);

`ifdef SRAM_VIDEO_PORT_WRITE_EN
      vid_active = 1'b1; wr_req = 1'b1; wr_addr = 20'h12345; wr_data = 16'hBEEF;
      for (int i = 0; i < 10; i++) begin
         rand_coords();
         step();
         check_eq("prio_we", we, 1);
         check_eq("prio_dq_oe", dq_oe, 0);
      end
      vid_active = 1'b0;
      step();
      check_eq("wr1_dq_oe", dq_oe, 1);
      check_eq("wr1_we", we, 1);
      check_eq("wr1_addr", sram_addr, 20'h12345);
      check_eq("wr1_data", dq_out, 16'hBEEF);
      step();
      check_eq("wr2_we", we, 0);
      check_eq("wr2_dq_oe", dq_oe, 1);
      step();
      check_eq("wr3_ack", wr_ack, 1);
      check_eq("wr3_we", we, 1);
      check_eq("wr3_dq_oe", dq_oe, 1);
      wr_req = 1'b0;
      step();
      check_eq("wr4_dq_oe", dq_oe, 0);
      check_eq("wr4_ack", wr_ack, 0);

      // reset while WE is low
      wr_req = 1'b1; wr_addr = 20'($urandom); wr_data = 16'($urandom);
      step();
      step();
      check_eq("rp_pulse_we", we, 0);
      reset = 1'b1; wr_req = 1'b0;
      step();
      check_eq("rp_we", we, 1);
      check_eq("rp_dq_oe", dq_oe, 0);
      check_eq("rp_ack", wr_ack, 0);
      check_eq("rp_pixel", pixel, 0);
      reset = 1'b0;
      step();
      check_eq("rp_oe", oe, 0);
      check_eq("rp_ack2", wr_ack, 0);
      check_eq("rp_pixel2", pixel, 0);
      check_eq("rp_valid2", pixel_valid, 0);
`else
      vid_active = 1'b0; wr_req = 1'b1; wr_addr = 20'h12345; wr_data = 16'hBEEF;
      for (int i = 0; i < 5; i++) begin
         rand_coords();
         step();
         check_eq("nowr_we", we, 1);
         check_eq("nowr_dq_oe", dq_oe, 0);
         check_eq("nowr_ack", wr_ack, 0);
         check_eq("nowr_oe", oe, 0);
      end
      wr_req = 1'b0;
`endif

      // randomised traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rand_coords();
         if ($urandom_range(0, 9) == 0) vid_active = !vid_active;
         reset = ($urandom_range(0, 99) == 0);
         if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req  = 1'b1;
            wr_addr = 20'($urandom);
            wr_data = 16'($urandom);
         end
         step();
         if (model_ack() || (!WR_EN && $urandom_range(0, 7) == 0)) wr_req = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sram_video_port.md
# sram_video_port

Parametrised SRAM port between the VGA pixel pipeline and the external asynchronous SRAM. It generalises scrolled frame-buffer address generation with configurable row stride, word width and pixel width. It unpacks sub-word pixels through a two-stage registered read pipeline. It also adds an arbitrated write channel so frame data can be loaded during blanking.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- PIX_W, 8, pixel width; DATA_W must be a power-of-two multiple of PIX_W; PPW = DATA_W/PIX_W
- ROW_STRIDE, 4114, pixels per frame-buffer row
- FPTR_W, 13, scroll pointer width

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- VidActive  in  1  display fetching; reads take priority
- DrawX  in  10  pixel column
- DrawY  in  10  pixel row
- FramePtr  in  FPTR_W  horizontal scroll offset, in pixels
- WrReq  in  1  write request; held until WrAck
- WrAddr  in  ADDR_W  write word address
- WrData  in  DATA_W  write data
- WrAck  out  1  one-cycle pulse when the write completes
- SRAM_Addr  out  ADDR_W  SRAM address, registered
- SRAM_DQ_In  in  DATA_W  SRAM read data
- SRAM_DQ_Out  out  DATA_W  SRAM write data
- SRAM_DQ_OE  out  1  drive enable for the top-level DQ tristate
- CE, UB, LB, OE, WE  out  1 each  active-low SRAM controls
- Pixel  out  PIX_W  unpacked pixel
- PixelValid  out  1  Pixel corresponds to an active-video fetch

## Operation
- Address arithmetic:
  - LIN_W = ADDR_W + log2(PPW).
  - lin = FramePtr + DrawX + DrawY*ROW_STRIDE, with operands zero-extended and the sum truncated modulo 2^LIN_W.
  - Word address = lin >> log2(PPW); pixel index k = lin[log2(PPW)-1:0].
- Pixel k of a word occupies bits [k*PIX_W +: PIX_W].
- CE, UB, LB are tied 0.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD.
- IDLE (read):
  - Drives SRAM_Addr = word address, OE=0, WE=1, SRAM_DQ_OE=0.
  - Reads every cycle regardless of VidActive.
- IDLE → W_SETUP when WrReq=1 and VidActive=0.
- W_SETUP: SRAM_Addr=WrAddr, SRAM_DQ_Out=WrData, OE=1, WE=1, SRAM_DQ_OE=1.
- W_PULSE: WE=0; address, data and drive unchanged.
- W_HOLD: WE=1, SRAM_DQ_OE=1, WrAck=1; next state IDLE.
- A write, once started, always completes; VidActive rising mid-write does not abort it.
- Read slots lost to a write produce PixelValid=0 and Pixel=0.
- Back-to-back writes: if WrReq is still high in IDLE, a new write starts; at least one IDLE cycle separates writes.
- WrReq is only sampled in IDLE, so a new request is taken in the cycle after WrAck.

## Timing
- Read latency is 2 cycles:
  - DrawX/DrawY/FramePtr sampled at edge n.
  - SRAM_Addr valid after edge n+1, with k delayed alongside.
  - SRAM_DQ_In captured at edge n+2; Pixel and PixelValid valid after edge n+2.
- PixelValid = VidActive delayed 2 cycles, ANDed with "slot was a read".
- A write occupies exactly 3 cycles. WE is low for exactly 1 cycle, with address and data stable one cycle before and one cycle after.
- Reset values:
  - FSM IDLE, SRAM_Addr=0, SRAM_DQ_Out=0, SRAM_DQ_OE=0.
  - OE=1, WE=1, WrAck=0, Pixel=0, PixelValid=0.
  - Pipeline registers cleared.
- Reset mid-write: on the next edge WE=1 and SRAM_DQ_OE=0, state is IDLE, and no WrAck is issued.

## Configuration
- SRAM_VIDEO_PORT_WRITE_EN defined: the write channel and FSM are built as above.
- Not defined:
  - No FSM.
  - WE=1, SRAM_DQ_OE=0, SRAM_DQ_Out=0, WrAck=0 constantly; WrReq/WrAddr/WrData are ignored.
  - Reads never stall.

## Test plan
- Read unpack (defaults): FramePtr=0, DrawX=3, DrawY=1, VidActive=1; SRAM_DQ_In=0xABCD at the capture cycle → SRAM_Addr=2058 one cycle later, Pixel=0xAB with PixelValid=1 two cycles later.
- Blanking write: VidActive=0, WrReq=1, WrAddr=0x12345, WrData=0xBEEF → SRAM_DQ_OE high 3 cycles with SRAM_DQ_Out=0xBEEF, WE low only in cycle 2, WrAck pulse in cycle 3.
- Priority: WrReq=1 while VidActive=1 for 10 cycles → WE stays 1; the write starts the cycle after VidActive falls.
- Address wrap: ADDR_W=10, DrawX=0, DrawY=1, FramePtr=0 → lin=4114 mod 2048=18, SRAM_Addr=9, k=0.
- Reset in W_PULSE → next cycle WE=1, SRAM_DQ_OE=0, OE=0; no WrAck; Pixel=0, PixelValid=0 for 2 cycles.
- Macro undefined: WrReq=1 with VidActive=0 for 5 cycles → WE=1, SRAM_DQ_OE=0, WrAck=0 throughout; reads continue.
